// File: rtl/alarm_bank_if.sv
// alarm_bank_if: running-clock inputs, edit/dismiss controls and per-channel
// status of an alarm_bank. master drives the controls, slave is the bank.
interface alarm_bank_if #(
  parameter int unsigned NUM_ALARMS = 2
);
  localparam int unsigned SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic                  sec_tick_pi;
  logic [5:0]            clock_seconds_pi;
  logic [5:0]            clock_minutes_pi;
  logic [4:0]            clock_hours_pi;
  logic [SEL_W-1:0]      sel_pi;
  logic                  inc_minute_pi;
  logic                  inc_hour_pi;
  logic [NUM_ALARMS-1:0] alarm_en_pi;
  logic                  ack_pi;
  logic                  snooze_pi;
  logic [5:0]            sel_minutes_po;
  logic [4:0]            sel_hours_po;
  logic [NUM_ALARMS-1:0] ringing_po;
  logic [NUM_ALARMS-1:0] snoozed_po;
  logic                  any_ringing_po;

  modport master (
    output sec_tick_pi, clock_seconds_pi, clock_minutes_pi, clock_hours_pi,
    output sel_pi, inc_minute_pi, inc_hour_pi, alarm_en_pi, ack_pi, snooze_pi,
    input  sel_minutes_po, sel_hours_po, ringing_po, snoozed_po, any_ringing_po
  );

  modport slave (
    input  sec_tick_pi, clock_seconds_pi, clock_minutes_pi, clock_hours_pi,
    input  sel_pi, inc_minute_pi, inc_hour_pi, alarm_en_pi, ack_pi, snooze_pi,
    output sel_minutes_po, sel_hours_po, ringing_po, snoozed_po, any_ringing_po
  );
endinterface

// File: rtl/alarm_bank.sv
// alarm_bank: NUM_ALARMS independent alarm channels, each with an editable
// alarm time, a match-edge trigger and an IDLE/ARMED/RINGING/SNOOZED FSM with
// ring auto-timeout. Snooze support is built only when ALARM_SNOOZE_EN is
// defined; otherwise snooze_pi is ignored and snoozed_po reads 0.
module alarm_bank #(
  parameter int unsigned NUM_ALARMS     = 2,
  parameter int unsigned HOUR_MODE      = 12,
  parameter int unsigned SNOOZE_MIN     = 9,
  parameter int unsigned RING_TIMEOUT_S = 60
) (
  input  logic        clk_pi,
  input  logic        rst_pi,
  alarm_bank_if.slave bus
);

  localparam int unsigned RING_W   = $clog2(RING_TIMEOUT_S + 1);
  localparam logic [4:0]  RST_HOUR = (HOUR_MODE == 12) ? 5'd12 : 5'd0;
`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SNZ_TOT  = SNOOZE_MIN * 60;
  localparam int unsigned SNZ_W    = $clog2(SNZ_TOT + 1);
`endif

  // Elaboration-time guard on the supported parameter ranges
  if (NUM_ALARMS < 1 || NUM_ALARMS > 8 || (HOUR_MODE != 12 && HOUR_MODE != 24) ||
      SNOOZE_MIN < 1 || SNOOZE_MIN > 59 ||
      RING_TIMEOUT_S < 1 || RING_TIMEOUT_S > 1023) begin : g_bad_params
    $error("alarm_bank: parameter out of supported range");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZED = 2'd3
  } state_t;

  logic [5:0]            r_min [NUM_ALARMS];
  logic [4:0]            r_hr  [NUM_ALARMS];
  state_t                r_state     [NUM_ALARMS];
  state_t                w_state_nxt [NUM_ALARMS];
  logic [RING_W-1:0]     r_ring_tmr     [NUM_ALARMS];
  logic [RING_W-1:0]     w_ring_tmr_nxt [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] w_match;
  logic [NUM_ALARMS-1:0] r_match;
  logic [NUM_ALARMS-1:0] w_trig;
  logic [NUM_ALARMS-1:0] w_ringing_nxt;
  logic [NUM_ALARMS-1:0] r_ringing;
  logic                  r_any_ringing;
`ifdef ALARM_SNOOZE_EN
  logic [SNZ_W-1:0]      r_snz_tmr     [NUM_ALARMS];
  logic [SNZ_W-1:0]      w_snz_tmr_nxt [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] w_snoozed_nxt;
  logic [NUM_ALARMS-1:0] r_snoozed;
`else
  logic                  w_unused_snooze;
  assign w_unused_snooze = bus.snooze_pi;
`endif

  // Next hour value, wrapping within the configured time base
  function automatic logic [4:0] f_hr_inc(input logic [4:0] hr);
    if (HOUR_MODE == 12) return (hr >= 5'd12) ? 5'd1 : hr + 5'd1;
    return (hr >= 5'd23) ? 5'd0 : hr + 5'd1;
  endfunction

  // Alarm time registers, edited only through the selected channel
  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_min[i] <= '0;
        r_hr[i]  <= RST_HOUR;
      end
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (32'(bus.sel_pi) == 32'(i)) begin
          if (bus.inc_minute_pi) r_min[i] <= (r_min[i] >= 6'd59) ? 6'd0 : r_min[i] + 6'd1;
          if (bus.inc_hour_pi)   r_hr[i]  <= f_hr_inc(r_hr[i]);
        end
      end
    end
  end

  // Readback of the selected channel; out-of-range selects read 0:0
  always_comb begin
    bus.sel_minutes_po = '0;
    bus.sel_hours_po   = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (32'(bus.sel_pi) == 32'(i)) begin
        bus.sel_minutes_po = r_min[i];
        bus.sel_hours_po   = r_hr[i];
      end
    end
  end

  // Exact-second match against the running clock
  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      w_match[i] = (bus.clock_seconds_pi == 6'd0) &&
                   (bus.clock_minutes_pi == r_min[i]) &&
                   (bus.clock_hours_pi   == r_hr[i]);
    end
  end

  // Only the rising edge fires, so an ack inside the matching second sticks
  assign w_trig = w_match & ~r_match;

  // Per-channel next state and timers; disable beats ack beats snooze beats timers
  always_comb begin
    w_ringing_nxt = '0;
`ifdef ALARM_SNOOZE_EN
    w_snoozed_nxt = '0;
`endif
    for (int i = 0; i < NUM_ALARMS; i++) begin
      w_state_nxt[i]    = r_state[i];
      w_ring_tmr_nxt[i] = r_ring_tmr[i];
`ifdef ALARM_SNOOZE_EN
      w_snz_tmr_nxt[i]  = r_snz_tmr[i];
`endif
      if (!bus.alarm_en_pi[i]) begin
        w_state_nxt[i] = ST_IDLE;
      end else begin
        case (r_state[i])
          ST_IDLE: w_state_nxt[i] = ST_ARMED;
          ST_ARMED: begin
            if (w_trig[i]) begin
              w_state_nxt[i]    = ST_RINGING;
              w_ring_tmr_nxt[i] = RING_W'(RING_TIMEOUT_S);
            end
          end
          ST_RINGING: begin
            if (bus.ack_pi) begin
              w_state_nxt[i] = ST_ARMED;
            end
`ifdef ALARM_SNOOZE_EN
            else if (bus.snooze_pi) begin
              w_state_nxt[i]   = ST_SNOOZED;
              w_snz_tmr_nxt[i] = SNZ_W'(SNZ_TOT);
            end
`endif
            else if (bus.sec_tick_pi) begin
              if (r_ring_tmr[i] <= RING_W'(1)) w_state_nxt[i] = ST_ARMED;
              else w_ring_tmr_nxt[i] = r_ring_tmr[i] - RING_W'(1);
            end
          end
`ifdef ALARM_SNOOZE_EN
          ST_SNOOZED: begin
            if (bus.ack_pi) begin
              w_state_nxt[i] = ST_ARMED;
            end else if (bus.sec_tick_pi) begin
              if (r_snz_tmr[i] <= SNZ_W'(1)) begin
                w_state_nxt[i]    = ST_RINGING;
                w_ring_tmr_nxt[i] = RING_W'(RING_TIMEOUT_S);
              end else begin
                w_snz_tmr_nxt[i] = r_snz_tmr[i] - SNZ_W'(1);
              end
            end
          end
`endif
          default: w_state_nxt[i] = ST_IDLE;
        endcase
      end
      w_ringing_nxt[i] = (w_state_nxt[i] == ST_RINGING);
`ifdef ALARM_SNOOZE_EN
      w_snoozed_nxt[i] = (w_state_nxt[i] == ST_SNOOZED);
`endif
    end
  end

  // State, timer, match history and registered status outputs
  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_state[i]    <= ST_IDLE;
        r_ring_tmr[i] <= '0;
`ifdef ALARM_SNOOZE_EN
        r_snz_tmr[i]  <= '0;
`endif
      end
      r_match       <= '0;
      r_ringing     <= '0;
      r_any_ringing <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      r_snoozed     <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_state[i]    <= w_state_nxt[i];
        r_ring_tmr[i] <= w_ring_tmr_nxt[i];
`ifdef ALARM_SNOOZE_EN
        r_snz_tmr[i]  <= w_snz_tmr_nxt[i];
`endif
      end
      r_match       <= w_match;
      r_ringing     <= w_ringing_nxt;
      r_any_ringing <= |w_ringing_nxt;
`ifdef ALARM_SNOOZE_EN
      r_snoozed     <= w_snoozed_nxt;
`endif
    end
  end

  assign bus.ringing_po     = r_ringing;
  assign bus.any_ringing_po = r_any_ringing;
`ifdef ALARM_SNOOZE_EN
  assign bus.snoozed_po     = r_snoozed;
`else
  assign bus.snoozed_po     = '0;
`endif

endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: directed vector tables and hand sequences on a 2-channel
// 12h bank and a 3-channel 24h bank, then random traffic on the 12h bank
// compared against a behavioural model of the alarm rules.
module tb_alarm_bank;
  localparam int RT = 3;
  localparam int SM = 1;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_ON = 1'b1;
`else
  localparam bit SNZ_ON = 1'b0;
`endif
  localparam int S_IDLE = 0;
  localparam int S_ARMED = 1;
  localparam int S_RING = 2;
  localparam int S_SNZ = 3;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   errors;
  int   checks;

  alarm_bank_if #(.NUM_ALARMS(2)) ifa ();
  alarm_bank_if #(.NUM_ALARMS(3)) ifb ();

  alarm_bank #(.NUM_ALARMS(2), .HOUR_MODE(12), .SNOOZE_MIN(SM), .RING_TIMEOUT_S(RT))
    u_dut_a (.clk_pi(clk), .rst_pi(rst_a), .bus(ifa));
  alarm_bank #(.NUM_ALARMS(3), .HOUR_MODE(24), .SNOOZE_MIN(9), .RING_TIMEOUT_S(60))
    u_dut_b (.clk_pi(clk), .rst_pi(rst_b), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       sel;
    bit       im;
    bit       ih;
    bit [1:0] en;
    bit       ack;
    bit       snz;
    bit       tick;
    int       h;
    int       m;
    int       s;
    bit [1:0] xr;
    bit [1:0] xs;
    int       xm;
    int       xh;
  } vec_t;

  vec_t t_rst[$];
  vec_t t_ring[$];
  vec_t t_post[$];

  // behavioural model of the 12h bank
  int m_min[2];
  int m_hr[2];
  int m_st[2];
  int m_left[2];
  bit m_prev[2];

  function automatic vec_t mk(input bit rst, input bit sel, input bit im, input bit ih,
                              input bit [1:0] en, input bit ack, input bit snz, input bit tick,
                              input int h, input int m, input int s,
                              input bit [1:0] xr, input bit [1:0] xs, input int xm, input int xh);
    vec_t v;
    v.rst = rst; v.sel = sel; v.im = im; v.ih = ih; v.en = en;
    v.ack = ack; v.snz = snz; v.tick = tick; v.h = h; v.m = m; v.s = s;
    v.xr = xr; v.xs = xs; v.xm = xm; v.xh = xh;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input bit rst, input bit sel, input bit im, input bit ih, input bit [1:0] en,
                       input bit ack, input bit snz, input bit tick, input int h, input int m, input int s);
    rst_a                = rst;
    ifa.sel_pi           = sel;
    ifa.inc_minute_pi    = im;
    ifa.inc_hour_pi      = ih;
    ifa.alarm_en_pi      = en;
    ifa.ack_pi           = ack;
    ifa.snooze_pi        = snz;
    ifa.sec_tick_pi      = tick;
    ifa.clock_hours_pi   = 5'(h);
    ifa.clock_minutes_pi = 6'(m);
    ifa.clock_seconds_pi = 6'(s);
  endtask

  task automatic drv_b(input bit rst, input int sel, input bit im, input bit ih);
    rst_b                = rst;
    ifb.sel_pi           = 2'(sel);
    ifb.inc_minute_pi    = im;
    ifb.inc_hour_pi      = ih;
    ifb.alarm_en_pi      = 3'b000;
    ifb.ack_pi           = 1'b0;
    ifb.snooze_pi        = 1'b0;
    ifb.sec_tick_pi      = 1'b0;
    ifb.clock_hours_pi   = 5'd3;
    ifb.clock_minutes_pi = 6'd4;
    ifb.clock_seconds_pi = 6'd5;
  endtask

  task automatic chk_a(input string name, input bit [1:0] xr, input bit [1:0] xs, input int xm, input int xh);
    check({name, " ringing"}, int'(ifa.ringing_po), int'(xr));
    check({name, " snoozed"}, int'(ifa.snoozed_po), int'(xs));
    check({name, " any"}, int'(ifa.any_ringing_po), int'(|xr));
    check({name, " sel_min"}, int'(ifa.sel_minutes_po), xm);
    check({name, " sel_hr"}, int'(ifa.sel_hours_po), xh);
  endtask

  task automatic apply_vec(input vec_t v, input string name);
    drv_a(v.rst, v.sel, v.im, v.ih, v.en, v.ack, v.snz, v.tick, v.h, v.m, v.s);
    step();
    chk_a(name, v.xr, v.xs, v.xm, v.xh);
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit hit;
      bit rise;
      hit  = (int'(ifa.clock_seconds_pi) == 0) && (int'(ifa.clock_minutes_pi) == m_min[i]) &&
             (int'(ifa.clock_hours_pi) == m_hr[i]);
      rise = hit && !m_prev[i];
      if (rst_a) begin
        m_min[i] = 0; m_hr[i] = 12; m_st[i] = S_IDLE; m_left[i] = 0; m_prev[i] = 1'b0;
      end else begin
        m_prev[i] = hit;
        if (!ifa.alarm_en_pi[i]) m_st[i] = S_IDLE;
        else if (m_st[i] == S_IDLE) m_st[i] = S_ARMED;
        else if (m_st[i] == S_ARMED) begin
          if (rise) begin m_st[i] = S_RING; m_left[i] = RT; end
        end
        else if (ifa.ack_pi) m_st[i] = S_ARMED;
        else if (m_st[i] == S_RING && ifa.snooze_pi && SNZ_ON) begin
          m_st[i] = S_SNZ; m_left[i] = SM * 60;
        end
        else if (ifa.sec_tick_pi) begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) begin
            if (m_st[i] == S_RING) m_st[i] = S_ARMED;
            else begin m_st[i] = S_RING; m_left[i] = RT; end
          end
        end
        if (int'(ifa.sel_pi) == i) begin
          if (ifa.inc_minute_pi) m_min[i] = (m_min[i] + 1) % 60;
          if (ifa.inc_hour_pi) m_hr[i] = m_hr[i] % 12 + 1;
        end
      end
    end
  endtask

  initial begin
    bit [1:0] ren;
    int ch;
    int cm;
    int cs;
    errors = 0;
    checks = 0;
    drv_a(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1, 2, 3);
    drv_b(1'b1, 0, 1'b0, 1'b0);

    // reset and readback of both channels
    t_rst.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2, 3, 2'b00, 2'b00, 0, 12));
    t_rst.push_back(mk(0, 1, 0, 0, 2'b00, 0, 0, 0, 1, 2, 3, 2'b00, 2'b00, 0, 12));
    t_rst.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2, 3, 2'b00, 2'b00, 0, 12));

    // ch0 alarm at 07:30: trigger, ack, retrigger rules, timeout, snooze
    t_ring.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 7, 29, 59, 2'b00, 2'b00, 30, 7));
    t_ring.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 7, 30, 0, 2'b01, 2'b00, 30, 7));
    t_ring.push_back(mk(0, 0, 0, 0, 2'b01, 1, 0, 0, 7, 30, 0, 2'b00, 2'b00, 30, 7));
    t_ring.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 7, 30, 0, 2'b00, 2'b00, 30, 7));
    t_ring.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 7, 30, 1, 2'b00, 2'b00, 30, 7));
    t_ring.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 7, 30, 0, 2'b01, 2'b00, 30, 7));
    t_ring.push_back(mk(0, 0, 0, 0, 2'b00, 1, 0, 0, 7, 30, 0, 2'b00, 2'b00, 30, 7));
    t_ring.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 7, 30, 0, 2'b00, 2'b00, 30, 7));
    t_ring.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 7, 30, 1, 2'b00, 2'b00, 30, 7));
    t_ring.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 7, 30, 0, 2'b01, 2'b00, 30, 7));
    t_ring.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 1, 7, 30, 0, 2'b01, 2'b00, 30, 7));
    t_ring.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 7, 30, 0, 2'b01, 2'b00, 30, 7));
    t_ring.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 1, 7, 30, 0, 2'b01, 2'b00, 30, 7));
    t_ring.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 1, 7, 30, 0, 2'b00, 2'b00, 30, 7));
    t_ring.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 7, 30, 1, 2'b00, 2'b00, 30, 7));
    t_ring.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 7, 30, 0, 2'b01, 2'b00, 30, 7));
    t_ring.push_back(mk(0, 0, 0, 0, 2'b01, 0, 1, 0, 7, 30, 0,
                        SNZ_ON ? 2'b00 : 2'b01, SNZ_ON ? 2'b01 : 2'b00, 30, 7));

    // dismiss, reset mid-ring, then ring at the reset time 12:00
    t_post.push_back(mk(0, 0, 0, 0, 2'b01, 1, 0, 0, 7, 30, 5, 2'b00, 2'b00, 30, 7));
    t_post.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 7, 30, 1, 2'b00, 2'b00, 30, 7));
    t_post.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 7, 30, 0, 2'b01, 2'b00, 30, 7));
    t_post.push_back(mk(1, 0, 0, 0, 2'b01, 0, 0, 0, 7, 30, 0, 2'b00, 2'b00, 0, 12));
    t_post.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 7, 30, 0, 2'b00, 2'b00, 0, 12));
    t_post.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 12, 0, 0, 2'b01, 2'b00, 0, 12));
    t_post.push_back(mk(0, 0, 0, 0, 2'b11, 0, 0, 0, 12, 0, 0, 2'b01, 2'b00, 0, 12));
    t_post.push_back(mk(0, 0, 0, 0, 2'b10, 0, 0, 0, 12, 0, 0, 2'b00, 2'b00, 0, 12));

    foreach (t_rst[i]) apply_vec(t_rst[i], $sformatf("rst_row%0d", i));

    // ch1: 60 minute increments wrap with no hour carry, 13 hour increments wrap 12->1
    for (int k = 1; k <= 60; k++) begin
      drv_a(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1, 2, 3);
      step();
      chk_a($sformatf("min_inc%0d", k), 2'b00, 2'b00, k % 60, 12);
    end
    for (int k = 1; k <= 13; k++) begin
      drv_a(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1, 2, 3);
      step();
      chk_a($sformatf("hr_inc%0d", k), 2'b00, 2'b00, 0, (11 + k) % 12 + 1);
    end
    drv_a(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1, 2, 3);
    step();
    chk_a("both_inc", 2'b00, 2'b00, 1, 2);

    // ch0 -> 07:30
    for (int k = 0; k < 7; k++) begin
      drv_a(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1, 2, 3);
      step();
    end
    for (int k = 0; k < 30; k++) begin
      drv_a(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1, 2, 3);
      step();
    end
    chk_a("set_0730", 2'b00, 2'b00, 30, 7);

    foreach (t_ring[i]) apply_vec(t_ring[i], $sformatf("ring_row%0d", i));

    // 60 seconds after the snooze request
    for (int k = 1; k <= 60; k++) begin
      drv_a(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 7, 30, 5);
      step();
      if (SNZ_ON) chk_a($sformatf("snz_tick%0d", k), (k == 60) ? 2'b01 : 2'b00, (k < 60) ? 2'b01 : 2'b00, 30, 7);
      else chk_a($sformatf("snz_tick%0d", k), (k < 3) ? 2'b01 : 2'b00, 2'b00, 30, 7);
    end

    foreach (t_post[i]) apply_vec(t_post[i], $sformatf("post_row%0d", i));

    // 24h bank: hour wrap 23->0 and out-of-range select
    drv_b(1'b1, 0, 1'b0, 1'b0);
    step();
    check("b_rst hr", int'(ifb.sel_hours_po), 0);
    check("b_rst min", int'(ifb.sel_minutes_po), 0);
    for (int k = 1; k <= 24; k++) begin
      drv_b(1'b0, 0, 1'b0, 1'b1);
      step();
      check($sformatf("b_hr_inc%0d", k), int'(ifb.sel_hours_po), k % 24);
    end
    for (int k = 1; k <= 4; k++) begin
      drv_b(1'b0, 3, 1'b1, 1'b1);
      step();
      check($sformatf("b_sel3_min%0d", k), int'(ifb.sel_minutes_po), 0);
      check($sformatf("b_sel3_hr%0d", k), int'(ifb.sel_hours_po), 0);
    end
    drv_b(1'b0, 2, 1'b1, 1'b0);
    step();
    check("b_ch2 min", int'(ifb.sel_minutes_po), 1);
    drv_b(1'b0, 1, 1'b0, 1'b0);
    step();
    check("b_ch1 min", int'(ifb.sel_minutes_po), 0);
    check("b_ch1 hr", int'(ifb.sel_hours_po), 0);
    drv_b(1'b0, 0, 1'b0, 1'b0);
    step();
    check("b_ch0 min", int'(ifb.sel_minutes_po), 0);
    check("b_ch0 hr", int'(ifb.sel_hours_po), 0);
    check("b_ringing", int'(ifb.ringing_po), 0);

    // random traffic on the 12h bank against the model
    drv_a(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1, 2, 3);
    model_step();
    step();
    ren = 2'b11;
    ch = 12; cm = 0; cs = 0;
    for (int c = 0; c < 2000; c++) begin
      int pick;
      bit rsel;
      bit [1:0] xr;
      bit [1:0] xs;
      if ($urandom_range(0, 3) == 0) begin
        pick = int'($urandom_range(0, 3));
        if (pick < 2) begin
          ch = m_hr[pick]; cm = m_min[pick];
        end else begin
          ch = int'($urandom_range(1, 12)); cm = int'($urandom_range(0, 59));
        end
        cs = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 59));
      end
      if ($urandom_range(0, 49) == 0) ren = 2'($urandom_range(0, 3));
      rsel = 1'($urandom_range(0, 1));
      drv_a($urandom_range(0, 999) == 0, rsel, $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0,
            ren, $urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
            ch, cm, cs);
      model_step();
      step();
      xr = {m_st[1] == S_RING, m_st[0] == S_RING};
      xs = {m_st[1] == S_SNZ, m_st[0] == S_SNZ};
      chk_a($sformatf("rand%0d", c), xr, xs, m_min[int'(rsel)], m_hr[int'(rsel)]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
